// File: rtl/sum_accumulator.sv
// sum_accumulator: adds COUNT {cout,sum} adder results per batch with a sticky overflow flag and a done pulse.
// Latency: acc reflects an accept on the next edge; backpressure: in_ready is high only while accumulating.
module sum_accumulator #(
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       sum,
    input  logic             cout,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(COUNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_in_ready;
    logic             r_done;

    logic [ACC_W:0]   w_operand;
    logic [ACC_W:0]   w_acc_sum;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             w_last;

    // One extra bit on the adder exposes the carry out of the accumulator MSB.
    assign w_operand = {{(ACC_W-4){1'b0}}, cout, sum};
    assign w_acc_sum = {1'b0, r_acc} + w_operand;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_accept  = in_valid && r_in_ready;
    assign w_last    = (w_cnt_nxt == CNT_W'(COUNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= ACCUM;
                        r_acc      <= '0;
                        r_ovf      <= 1'b0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_sum[ACC_W-1:0];
                        r_cnt <= w_cnt_nxt;
                        if (w_acc_sum[ACC_W]) begin
                            r_ovf <= 1'b1;
                        end
                        // Outputs are registered, so they move together with the state.
                        if (w_last) begin
                            r_state    <= DONE;
                            r_busy     <= 1'b0;
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign acc      = r_acc;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: two instances (ACC_W=8 and ACC_W=5) share one stimulus stream;
// expected batch totals are queued by the driver and checked by a monitor on each done pulse.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] sum;
    logic       cout;
    logic       in_valid;

    logic       rdy8, ovf8, busy8, done8;
    logic [7:0] acc8;
    logic       rdy5, ovf5, busy5, done5;
    logic [4:0] acc5;

    always #5 clk = ~clk;

    sum_accumulator #(.COUNT(4), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .sum(sum), .cout(cout),
        .in_valid(in_valid), .in_ready(rdy8), .acc(acc8), .ovf(ovf8),
        .busy(busy8), .done(done8)
    );

    sum_accumulator #(.COUNT(4), .ACC_W(5)) u_dut5 (
        .clk(clk), .rst(rst), .start(start), .sum(sum), .cout(cout),
        .in_valid(in_valid), .in_ready(rdy5), .acc(acc5), .ovf(ovf5),
        .busy(busy5), .done(done5)
    );

    typedef struct {
        int acc8;
        int ovf8;
        int acc5;
        int ovf5;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   n_done      = 0;
    int   last_acc8   = 0;
    int   last_acc5   = 0;
    int   ops_sum[4];
    int   ops_cout[4];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a batch total is the plain integer sum of its operands; overflow
    // happened at some step exactly when that unwrapped total reaches 2^ACC_W.
    function automatic exp_t model(input int total);
        exp_t e;
        e.acc8 = total % 256;
        e.ovf8 = (total >= 256) ? 1 : 0;
        e.acc5 = total % 32;
        e.ovf5 = (total >= 32) ? 1 : 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && (done8 || done5)) begin
            chk("done_align", int'(done5), int'(done8));
            n_done++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("acc8_at_done", int'(acc8), e.acc8);
                chk("ovf8_at_done", int'(ovf8), e.ovf8);
                chk("acc5_at_done", int'(acc5), e.acc5);
                chk("ovf5_at_done", int'(ovf5), e.ovf5);
                chk("busy_at_done", int'(busy8), 0);
            end
        end
    end

    task automatic random_ops();
        for (int i = 0; i < 4; i++) begin
            ops_sum[i]  = $urandom_range(0, 15);
            ops_cout[i] = $urandom_range(0, 1);
        end
    endtask

    task automatic set_ops(input int s0, input int c0, input int s1, input int c1,
                           input int s2, input int c2, input int s3, input int c3);
        ops_sum[0] = s0; ops_cout[0] = c0;
        ops_sum[1] = s1; ops_cout[1] = c1;
        ops_sum[2] = s2; ops_cout[2] = c2;
        ops_sum[3] = s3; ops_cout[3] = c3;
    endtask

    // Drives one batch from ops_*; gap cycles of in_valid=0 (random data) follow each sample.
    task automatic run_batch(input int gap, input bit mid_start, input bit done_start);
        int   total = 0;
        exp_t e;
        for (int i = 0; i < 4; i++) total += ops_cout[i] * 16 + ops_sum[i];
        e = model(total);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy8), 1);
        chk("acc_cleared", int'(acc8), 0);
        for (int i = 0; i < 4; i++) begin
            chk("in_ready_accum", int'(rdy8), 1);
            in_valid = 1'b1;
            sum      = 4'(ops_sum[i]);
            cout     = ops_cout[i][0];
            if (mid_start && i == 2) start = 1'b1;
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            if (done_start && i == 3) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("start_in_done_ignored", int'(busy8), 0);
            end
            for (int g = 0; g < gap; g++) begin
                sum  = 4'($urandom_range(0, 15));
                cout = 1'($urandom_range(0, 1));
                if (i < 3) chk("no_early_done", int'(done8), 0);
                @(negedge clk);
            end
        end
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("done_timeout", int'(exp_q.size()), 0);
            exp_q.delete();
        end
        last_acc8 = e.acc8;
        last_acc5 = e.acc5;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sum = '0; cout = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_acc", int'(acc8), 0);
        chk("rst_ovf", int'(ovf8), 0);
        chk("rst_busy", int'(busy8), 0);
        chk("rst_in_ready", int'(rdy8), 0);
        chk("rst_done", int'(done8), 0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal: 5+12+19+31 = 67; in 5 bits 67 wraps to 3 with overflow.
        set_ops(5, 0, 12, 0, 3, 1, 15, 1);
        run_batch(0, 1'b0, 1'b0);
        chk("hold_acc_idle", int'(acc8), 67);

        set_ops(15, 1, 15, 1, 0, 0, 0, 0);
        run_batch(0, 1'b0, 1'b0);

        set_ops(5, 0, 12, 0, 3, 1, 15, 1);
        run_batch(3, 1'b0, 1'b0);

        set_ops(5, 0, 12, 0, 3, 1, 15, 1);
        run_batch(0, 1'b1, 1'b1);

        // Inputs in IDLE must be ignored.
        in_valid = 1'b1; sum = 4'd9; cout = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("idle_acc8_hold", int'(acc8), last_acc8);
        chk("idle_acc5_hold", int'(acc5), last_acc5);
        chk("idle_in_ready", int'(rdy8), 0);

        // Reset after two accepts drops the batch without a done pulse.
        begin
            int done_before;
            done_before = n_done;
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                in_valid = 1'b1; sum = 4'd7; cout = 1'b1;
                @(negedge clk);
            end
            in_valid = 1'b1;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            in_valid = 1'b0;
            chk("mid_rst_acc8", int'(acc8), 0);
            chk("mid_rst_acc5", int'(acc5), 0);
            chk("mid_rst_ovf5", int'(ovf5), 0);
            chk("mid_rst_busy", int'(busy8), 0);
            chk("mid_rst_in_ready", int'(rdy8), 0);
            repeat (6) @(negedge clk);
            chk("mid_rst_no_done", n_done, done_before);
        end

        for (int b = 0; b < 20; b++) begin
            random_ops();
            run_batch(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
